// File: rtl/mul_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : mul_seq_driver
// Description : Sequencer in front of a 32x32 shift-add multiplier. Takes one
//               operand pair per valid/ready handshake, clears the multiplier,
//               runs it until Ready (or a cycle timeout), and presents the
//               registered 64-bit product with an error flag on a valid/ready
//               output.
//               Optional build macro SIGNED_MUL_EN: two's-complement operands
//               (magnitudes drive the multiplier, sign fixed up on capture).
// Revision    : 1.0 - initial release
// ============================================================================
module mul_seq_driver #(
    parameter int W       = 32,
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [W-1:0]     In_a,
    input  logic [W-1:0]     In_b,
    output logic [W-1:0]     Mul_Multiplicand,
    output logic [W-1:0]     Mul_Multiplier,
    output logic             Mul_Run,
    output logic             Mul_Reset,
    input  logic [2*W-1:0]   Mul_Product,
    input  logic             Mul_Ready,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [2*W-1:0]   Out_product,
    output logic             Out_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*W-1:0]     r_product;
    logic               r_err;
    logic               w_accept;
    logic               w_capture;
    logic               w_timeout;
    logic [W-1:0]       w_a_mag;
    logic [W-1:0]       w_b_mag;
    logic [2*W-1:0]     w_result;

`ifdef SIGNED_MUL_EN
    logic               r_neg;

    // The multiplier is unsigned: feed it magnitudes and correct the sign later.
    assign w_a_mag  = In_a[W-1] ? -In_a : In_a;
    assign w_b_mag  = In_b[W-1] ? -In_b : In_b;
    assign w_result = r_neg ? -Mul_Product : Mul_Product;

    // Result sign is fixed at accept time, alongside the operands.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_neg <= 1'b0;
        end else if (w_accept) begin
            r_neg <= In_a[W-1] ^ In_b[W-1];
        end
    end
`else
    assign w_a_mag  = In_a;
    assign w_b_mag  = In_b;
    assign w_result = Mul_Product;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/control outputs; Ready wins over the timeout.
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_capture = 1'b0;
        w_timeout = 1'b0;
        In_ready  = 1'b0;
        Mul_Run   = 1'b0;
        Out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                In_ready = 1'b1;
                if (In_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_CLR;
                end
            end
            S_CLR: begin
                w_next = S_RUN;
            end
            S_RUN: begin
                Mul_Run = ~Reset;
                if (Mul_Ready) begin
                    w_capture = 1'b1;
                    w_next    = S_DONE;
                end else if (r_cnt == c_cnt_last) begin
                    w_timeout = 1'b1;
                    w_next    = S_DONE;
                end
            end
            S_DONE: begin
                Out_valid = 1'b1;
                if (Out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, RUN cycle counter and result register.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a <= w_a_mag;
                r_b <= w_b_mag;
            end
            if (r_state == S_CLR) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_product <= w_result;
                r_err     <= 1'b0;
            end else if (w_timeout) begin
                r_product <= '0;
                r_err     <= 1'b1;
            end
        end
    end

    assign Mul_Reset        = Reset | (r_state == S_CLR);
    assign Mul_Multiplicand = r_a;
    assign Mul_Multiplier   = r_b;
    assign Out_product      = r_product;
    assign Out_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_seq_driver
// Description : Self-checking bench for mul_seq_driver with a behavioural
//               multiplier stub (healthy, late-Ready or hung) and a timeline
//               model of the sequencer. Honours SIGNED_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_seq_driver;

    localparam int W       = 32;
    localparam int TIMEOUT = 40;

    logic            clk = 1'b0;
    logic            Reset = 1'b1;
    logic            In_valid = 1'b0;
    logic            In_ready;
    logic [W-1:0]    In_a = '0;
    logic [W-1:0]    In_b = '0;
    logic [W-1:0]    Mul_Multiplicand;
    logic [W-1:0]    Mul_Multiplier;
    logic            Mul_Run;
    logic            Mul_Reset;
    logic [2*W-1:0]  Mul_Product;
    logic            Mul_Ready;
    logic            Out_valid;
    logic            Out_ready = 1'b0;
    logic [2*W-1:0]  Out_product;
    logic            Out_err;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mul_seq_driver #(.W(W), .TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .In_valid         (In_valid),
        .In_ready         (In_ready),
        .In_a             (In_a),
        .In_b             (In_b),
        .Mul_Multiplicand (Mul_Multiplicand),
        .Mul_Multiplier   (Mul_Multiplier),
        .Mul_Run          (Mul_Run),
        .Mul_Reset        (Mul_Reset),
        .Mul_Product      (Mul_Product),
        .Mul_Ready        (Mul_Ready),
        .Out_valid        (Out_valid),
        .Out_ready        (Out_ready),
        .Out_product      (Out_product),
        .Out_err          (Out_err)
    );

    // Multiplier stub: Ready rises once it has seen stub_target+1 Run cycles
    // (32 -> Ready during the 34th Run cycle); a negative target never finishes.
    int              stub_target = 32;
    int              st_cnt = 0;
    logic            st_rdy = 1'b0;
    logic [2*W-1:0]  st_prod = '0;

    always @(posedge clk) begin
        if (Mul_Reset) begin
            st_cnt  <= 0;
            st_rdy  <= 1'b0;
            st_prod <= '0;
        end else if (Mul_Run && !st_rdy) begin
            st_cnt <= st_cnt + 1;
            if (st_cnt == stub_target) begin
                st_rdy  <= 1'b1;
                st_prod <= 64'(Mul_Multiplicand) * 64'(Mul_Multiplier);
            end
        end
    end
    assign Mul_Ready   = st_rdy;
    assign Mul_Product = st_prod;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mag(input logic [31:0] v);
`ifdef SIGNED_MUL_EN
        return v[31] ? (32'd0 - v) : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
`ifdef SIGNED_MUL_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return 64'(a) * 64'(b);
`endif
    endfunction

    // Timeline model: cycle 'age' after the accept cycle, 1 = clear, then Run
    // until the result appears at age m_lat; held until Out_ready.
    logic        m_en   = 1'b0;
    logic        m_busy = 1'b0;
    int          m_acc  = 0;
    int          m_lat  = 0;
    int          m_age  = 0;
    logic [63:0] m_prod = '0;
    logic        m_err  = 1'b0;
    logic [31:0] m_opa  = '0;
    logic [31:0] m_opb  = '0;

    always @(negedge clk) begin
        m_age = cyc - m_acc;
        if (m_en) begin
            check("in_ready",  64'(In_ready),  64'(!m_busy));
            check("out_valid", 64'(Out_valid), 64'(m_busy && m_age >= m_lat));
            check("mul_reset", 64'(Mul_Reset), 64'(Reset || (m_busy && m_age == 1)));
            check("mul_run",   64'(Mul_Run),   64'(!Reset && m_busy && m_age >= 2 && m_age < m_lat));
            check("mul_a",     64'(Mul_Multiplicand), 64'(m_opa));
            check("mul_b",     64'(Mul_Multiplier),   64'(m_opb));
            if (m_busy && m_age >= m_lat) begin
                check("out_product", Out_product, m_prod);
                check("out_err",     64'(Out_err), 64'(m_err));
            end
        end
        if (Reset) begin
            m_en   = 1'b1;
            m_busy = 1'b0;
            m_opa  = '0;
            m_opb  = '0;
        end else if (m_en && !m_busy && In_valid) begin
            m_busy = 1'b1;
            m_acc  = cyc;
            m_opa  = mag(In_a);
            m_opb  = mag(In_b);
            if (stub_target >= 0 && stub_target + 2 <= TIMEOUT) begin
                m_lat  = stub_target + 4;
                m_err  = 1'b0;
                m_prod = ref_product(In_a, In_b);
            end else begin
                m_lat  = TIMEOUT + 2;
                m_err  = 1'b1;
                m_prod = '0;
            end
        end else if (m_busy && m_age >= m_lat && Out_ready) begin
            m_busy = 1'b0;
        end
    end

    // One transaction with literal expectations; optional junk In_valid while busy.
    task automatic run_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] exp, input logic exp_err,
                            input int exp_lat, input int hold, input bit junk);
        int  t0;
        bit  got;
        @(posedge clk); #1;
        In_a = a; In_b = b; In_valid = 1'b1; Out_ready = 1'b0;
        @(negedge clk);
        check("accept_ready", 64'(In_ready), 64'd1);
        t0 = cyc;
        @(posedge clk); #1;
        if (junk) begin
            In_a = ~a;
            In_b = 32'h1234;
        end else begin
            In_valid = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (Out_valid === 1'b1) got = 1'b1;
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL wait_out_valid: got timeout expected Out_valid within 100 cycles");
        end else begin
            check("latency",  64'(cyc - t0), 64'(exp_lat));
            check("result",   Out_product, exp);
            check("err_flag", 64'(Out_err), 64'(exp_err));
            repeat (hold) begin
                @(negedge clk);
                check("hold_product",  Out_product, exp);
                check("hold_in_ready", 64'(In_ready), 64'd0);
            end
        end
        @(posedge clk); #1;
        Out_ready = 1'b1; In_valid = 1'b0;
        @(posedge clk); #1;
        Out_ready = 1'b0;
        @(negedge clk);
        check("release_valid", 64'(Out_valid), 64'd0);
        check("release_ready", 64'(In_ready),  64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  64'(In_ready),  64'd1);
        check("rst_out_valid", 64'(Out_valid), 64'd0);
        check("rst_mul_reset", 64'(Mul_Reset), 64'd1);
        check("rst_product",   Out_product,    64'd0);
        check("rst_err",       64'(Out_err),   64'd0);
        @(posedge clk); #1;
        Reset = 1'b0;

        run_pair(32'd7, 32'd6, 64'h2A, 1'b0, 36, 0, 1'b0);
`ifdef SIGNED_MUL_EN
        run_pair(32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 1'b0, 36, 10, 1'b1);
`else
        run_pair(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, 36, 10, 1'b1);
`endif

        // Reset in the middle of RUN drops the result.
        @(posedge clk); #1;
        In_a = 32'd9; In_b = 32'd9; In_valid = 1'b1;
        @(posedge clk); #1;
        In_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1 Reset = 1'b1;
        @(posedge clk); #1;
        Reset = 1'b0;
        @(negedge clk);
        check("midrst_valid", 64'(Out_valid), 64'd0);
        check("midrst_ready", 64'(In_ready),  64'd1);
        check("midrst_opa",   64'(Mul_Multiplicand), 64'd0);
        run_pair(32'd3, 32'd5, 64'hF, 1'b0, 36, 0, 1'b0);

        // Hung multiplier: timeout after TIMEOUT Run cycles.
        stub_target = -1;
        run_pair(32'd11, 32'd13, 64'd0, 1'b1, 42, 0, 1'b0);
        // Ready arriving on the very last Run cycle beats the timeout.
        stub_target = 38;
        run_pair(32'd100, 32'd200, 64'd20000, 1'b0, 42, 0, 1'b0);
        stub_target = 32;

`ifdef SIGNED_MUL_EN
        run_pair(32'hFFFFFFFD, 32'd5, 64'hFFFFFFFFFFFFFFF1, 1'b0, 36, 0, 1'b0);
        run_pair(32'hFFFFFFFC, 32'hFFFFFFFC, 64'h10, 1'b0, 36, 0, 1'b0);
        run_pair(32'h80000000, 32'h80000000, 64'h4000000000000000, 1'b0, 36, 0, 1'b0);
`else
        run_pair(32'h80000000, 32'd2, 64'h100000000, 1'b0, 36, 0, 1'b0);
        run_pair(32'd0, 32'hDEADBEEF, 64'd0, 1'b0, 36, 0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
